fetch_seq: RTL and testbench

Instruction-fetch sequencer for the RV32 core. It owns the architectural fetch PC and turns each 32-bit instruction fetch into four byte reads on the shared byte-wide memory port. It assembles the bytes little-endian and presents the instruction to IF/ID with a valid/stall handshake. Branch/jump redirects from EX re-steer the PC and discard any in-flight fetch.

---
 rtl/fetch_seq.sv | 131 +++++++++++++
 tb/tb_fetch_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_seq: RV32 fetch sequencer, one 32-bit fetch as four byte reads.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_seq #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              stall_in,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] pc,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [1:0]          req_cnt_q, req_cnt_d;
  logic                pend_q, pend_d;
  logic [1:0]          pend_idx_q, pend_idx_d;
  logic [31:0]         asm_q, asm_d;
  logic [31:0]         inst_q, inst_d;
  logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
  logic                inst_valid_q, inst_valid_d;

  assign mem_req    = (state_q == S_FETCH) && rdy && !br_valid;
  assign mem_addr   = pc_q + ADDR_W'(req_cnt_q);
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_cnt_d    = req_cnt_q;
    pend_d       = pend_q;
    pend_idx_d   = pend_idx_q;
    asm_d        = asm_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    // Memory returns data regardless of rdy, so capture is never gated.
    if (pend_q) begin
      asm_d[{pend_idx_q, 3'b000} +: 8] = mem_din;
      pend_d = 1'b0;
    end

    if (rdy) begin
      if (br_valid) begin
        pc_d         = br_target;
        req_cnt_d    = 2'd0;
        pend_d       = 1'b0;
        inst_valid_d = 1'b0;
        state_d      = S_FETCH;
      end else begin
        case (state_q)
          S_FETCH: begin
            if (mem_gnt) begin
              pend_d     = 1'b1;
              pend_idx_d = req_cnt_q;
              req_cnt_d  = req_cnt_q + 2'd1;
              if (req_cnt_q == 2'd3) state_d = S_WAIT;
            end
          end
          S_WAIT: begin
            // Lane 3 may already have landed while rdy was low.
            if (!pend_q || (pend_idx_q == 2'd3)) begin
              inst_d       = asm_d;
              inst_pc_d    = pc_q;
              inst_valid_d = 1'b1;
              state_d      = S_HOLD;
            end
          end
          S_HOLD: begin
            if (!stall_in) begin
              inst_valid_d = 1'b0;
              pc_d         = pc_q + ADDR_W'(4);
              req_cnt_d    = 2'd0;
              state_d      = S_FETCH;
            end
          end
          default: state_d = S_FETCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      req_cnt_q    <= 2'd0;
      pend_q       <= 1'b0;
      pend_idx_q   <= 2'd0;
      asm_q        <= 32'd0;
      inst_q       <= 32'd0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_cnt_q    <= req_cnt_d;
      pend_q       <= pend_d;
      pend_idx_q   <= pend_idx_d;
      asm_q        <= asm_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_seq: directed bench with byte-memory model and fetch scoreboard.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic        stall_in = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b1;
  logic [7:0]  mem_din = 8'd0;
  logic [31:0] pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_seq #(.ADDR_W(32), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .stall_in(stall_in),
    .br_valid(br_valid), .br_target(br_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_din(mem_din),
    .pc(pc), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic        s_req, s_valid, prev_valid = 1'b0;
  logic [31:0] s_addr, s_inst, s_ipc;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return (a[7:0] ^ 8'h5A) + a[15:8] + 8'h11;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] p);
    return {mem_byte(p + 32'd3), mem_byte(p + 32'd2), mem_byte(p + 32'd1), mem_byte(p)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_fetch(input logic [31:0] p);
    exp_t e;
    e.word = exp_word(p);
    e.addr = p;
    sb.push_back(e);
  endtask

  // One clock cycle: sample at negedge, score new instructions, answer grants.
  task automatic step();
    logic        g;
    logic [31:0] a;
    exp_t        e;
    @(negedge clk);
    s_req = mem_req; s_addr = mem_addr; s_valid = inst_valid;
    s_inst = inst; s_ipc = inst_pc;
    g = mem_req && mem_gnt;
    a = mem_addr;
    if (inst_valid && !prev_valid) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL sb_empty observed=unexpected inst 0x%08h expected=no instruction", inst);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_inst", inst, e.word);
        check("sb_inst_pc", inst_pc, e.addr);
      end
    end
    prev_valid = inst_valid;
    @(posedge clk);
    #1;
    mem_din = g ? mem_byte(a) : 8'hEE;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(); step();
    check("rst_valid", {31'd0, s_valid}, 32'd0);
    check("rst_inst", s_inst, 32'd0);
    check("rst_inst_pc", s_ipc, 32'd0);
    check("rst_req", {31'd0, s_req}, 32'd0);
    check("rst_pc", pc, 32'd0);

    // Full-grant fetch from RESET_PC
    rst_n = 1'b1; rdy = 1'b1;
    push_fetch(32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_req", {31'd0, s_req}, 32'd1);
      check("t1_addr", s_addr, 32'(i));
    end
    step();
    check("t1_wait_req", {31'd0, s_req}, 32'd0);
    check("t1_wait_valid", {31'd0, s_valid}, 32'd0);
    step();
    check("t1_valid_c5", {31'd0, s_valid}, 32'd1);

    // Grant withheld in fetch cycles 1-2; stall asserted as the word arrives
    push_fetch(32'd4);
    for (int c = 0; c < 8; c++) begin
      mem_gnt = !(c == 1 || c == 2);
      if (c == 7) stall_in = 1'b1;
      step();
      if (c < 6) check("t2_addr", s_addr, (c == 0) ? 32'd4 : (c < 4) ? 32'd5 : (c == 4) ? 32'd6 : 32'd7);
      if (c == 6) check("t2_valid_c6", {31'd0, s_valid}, 32'd0);
      if (c == 7) check("t2_valid_c7", {31'd0, s_valid}, 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_hold_valid", {31'd0, s_valid}, 32'd1);
      check("t3_hold_req", {31'd0, s_req}, 32'd0);
      check("t3_hold_inst", s_inst, exp_word(32'd4));
      check("t3_hold_pc", s_ipc, 32'd4);
    end
    stall_in = 1'b0;
    step();
    step();
    check("t3_next_req", {31'd0, s_req}, 32'd1);
    check("t3_next_addr", s_addr, 32'd8);

    // Redirect the cycle after the byte-1 grant
    step();
    check("t4_b1_addr", s_addr, 32'd9);
    br_valid = 1'b1; br_target = 32'h100;
    step();
    check("t4_br_req", {31'd0, s_req}, 32'd0);
    br_valid = 1'b0;
    push_fetch(32'h100);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_addr", s_addr, 32'h100 + 32'(i));
    end
    step();
    step();
    check("t4_valid", {31'd0, s_valid}, 32'd1);

    // rdy low mid-fetch and in HOLD
    push_fetch(32'h104);
    step(); check("t5_addr0", s_addr, 32'h104);
    step(); check("t5_addr1", s_addr, 32'h105);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_rdy_req", {31'd0, s_req}, 32'd0);
    end
    rdy = 1'b1;
    step(); check("t5_addr2", s_addr, 32'h106);
    step(); check("t5_addr3", s_addr, 32'h107);
    step(); check("t5_wait_valid", {31'd0, s_valid}, 32'd0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_hold_valid", {31'd0, s_valid}, 32'd1);
      check("t5_hold_req", {31'd0, s_req}, 32'd0);
    end
    rdy = 1'b1;
    step();
    step();
    check("t5_next_addr", s_addr, 32'h108);
    check("t5_next_req", {31'd0, s_req}, 32'd1);

    // Asynchronous reset between edges, mid-fetch
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", {31'd0, inst_valid}, 32'd0);
    check("t6_inst", inst, 32'd0);
    check("t6_inst_pc", inst_pc, 32'd0);
    check("t6_pc", pc, 32'd0);
    check("t6_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    push_fetch(32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_refetch_addr", s_addr, 32'(i));
    end
    step();
    step();
    check("t6_valid_after", {31'd0, s_valid}, 32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
